// File: rtl/lc3b_types.sv
// lc3b_types
//   Shared type definitions for the LC-3b cache datapath. Holds the cache
//   tag/index/line/word types, the line mover FSM state encoding, and a
//   helper that builds a line-aligned physical memory address.
package lc3b_types;

  typedef logic [8:0]   lc3b_cache_tag;
  typedef logic [2:0]   lc3b_cache_index;
  typedef logic [127:0] lc3b_pmem_line;
  typedef logic [15:0]  lc3b_word;

  // Byte offset within a 16-byte line; the low address bits are always zero
  // for line transfers.
  localparam int OFFSET_W = 4;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WRITEBACK = 3'd1,
    FILL      = 3'd2,
    LOAD      = 3'd3,
    DONE      = 3'd4
  } lc3b_line_mover_state;

  // Concatenate tag and index into a line-aligned pmem address.
  function automatic lc3b_word lineAddr(input lc3b_cache_tag tag,
                                        input lc3b_cache_index index);
    return {tag, index, {OFFSET_W{1'b0}}};
  endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter
//   Event counter that stops at all-ones instead of wrapping.
//   Ports:
//     clk   - clock, counts on rising edge
//     reset - asynchronous active-high clear
//     inc   - count one event this cycle
//     count - current count
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] One = CNT_W'(1);

  logic [CNT_W-1:0] count_q;

  // Increment only while below the ceiling so the count pins at all-ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (inc && (count_q != '1)) begin
      count_q <= count_q + One;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/cache_line_mover.sv
// cache_line_mover
//   Miss-service engine between a cache_set array and physical memory.
//   On a miss it captures the victim line, writes it back if it is valid and
//   dirty, fetches the requested line, installs it as a memory fill and
//   pulses done for one cycle.
//   Ports:
//     clk, reset                       - clock, async active-high reset
//     req, req_tag, req_index          - miss request from the controller
//     victim_valid/dirty/tag/data      - current contents of set[set_index]
//     set_index, set_load,             - cache_set access and install port
//     set_write_type, set_in_tag, set_in_data
//     pmem_address, pmem_read,         - physical memory line port
//     pmem_write, pmem_wdata, pmem_rdata, pmem_resp
//     busy, done                       - status to the controller
//     wb_count, fill_count             - saturating event counters
module cache_line_mover
  import lc3b_types::*;
#(
  parameter int CNT_W = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req,
  input  lc3b_cache_tag   req_tag,
  input  lc3b_cache_index req_index,
  input  logic            victim_valid,
  input  logic            victim_dirty,
  input  lc3b_cache_tag   victim_tag,
  input  lc3b_pmem_line   victim_data,
  output lc3b_cache_index set_index,
  output logic            set_load,
  output logic            set_write_type,
  output lc3b_cache_tag   set_in_tag,
  output lc3b_pmem_line   set_in_data,
  output lc3b_word        pmem_address,
  output logic            pmem_read,
  output logic            pmem_write,
  output lc3b_pmem_line   pmem_wdata,
  input  lc3b_pmem_line   pmem_rdata,
  input  logic            pmem_resp,
  output logic            busy,
  output logic            done,
  output logic [CNT_W-1:0] wb_count,
  output logic [CNT_W-1:0] fill_count
);

  lc3b_line_mover_state state_q, state_d;
  lc3b_cache_tag        reqTag_q, reqTag_d;
  lc3b_cache_index      index_q, index_d;
  lc3b_cache_tag        victimTag_q, victimTag_d;
  lc3b_pmem_line        victimData_q, victimData_d;
  lc3b_pmem_line        line_q, line_d;

  logic wbDone;
  logic fillDone;

  // State and transaction latches. Reset aborts any transaction in flight;
  // because every strobe is decoded from state_q, the pmem request drops
  // as soon as reset rises.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      reqTag_q     <= '0;
      index_q      <= '0;
      victimTag_q  <= '0;
      victimData_q <= '0;
      line_q       <= '0;
    end else begin
      state_q      <= state_d;
      reqTag_q     <= reqTag_d;
      index_q      <= index_d;
      victimTag_q  <= victimTag_d;
      victimData_q <= victimData_d;
      line_q       <= line_d;
    end
  end

  // Next-state logic. The victim is captured at the accepting edge because
  // the set outputs follow set_index, which switches to the latched index
  // once we leave IDLE. An invalid victim never triggers a writeback even if
  // its dirty bit is stale. pmem_resp only matters in WRITEBACK and FILL.
  always_comb begin
    state_d      = state_q;
    reqTag_d     = reqTag_q;
    index_d      = index_q;
    victimTag_d  = victimTag_q;
    victimData_d = victimData_q;
    line_d       = line_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          reqTag_d     = req_tag;
          index_d      = req_index;
          victimTag_d  = victim_tag;
          victimData_d = victim_data;
          state_d      = (victim_valid && victim_dirty) ? WRITEBACK : FILL;
        end
      end
      WRITEBACK: begin
        if (pmem_resp) begin
          state_d = FILL;
        end
      end
      FILL: begin
        if (pmem_resp) begin
          line_d  = pmem_rdata;
          state_d = LOAD;
        end
      end
      LOAD:    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Moore output decode. Data outputs are forced to zero outside the state
  // that uses them so idle buses stay quiet.
  always_comb begin
    set_index      = (state_q == IDLE) ? req_index : index_q;
    set_load       = 1'b0;
    set_write_type = 1'b0;
    set_in_tag     = '0;
    set_in_data    = '0;
    pmem_address   = '0;
    pmem_read      = 1'b0;
    pmem_write     = 1'b0;
    pmem_wdata     = '0;
    busy           = (state_q != IDLE);
    done           = 1'b0;
    case (state_q)
      WRITEBACK: begin
        pmem_write   = 1'b1;
        pmem_address = lineAddr(victimTag_q, index_q);
        pmem_wdata   = victimData_q;
      end
      FILL: begin
        pmem_read    = 1'b1;
        pmem_address = lineAddr(reqTag_q, index_q);
      end
      LOAD: begin
        set_load    = 1'b1;
        set_in_tag  = reqTag_q;
        set_in_data = line_q;
      end
      DONE: begin
        done = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign wbDone   = (state_q == WRITEBACK) && pmem_resp;
  assign fillDone = (state_q == FILL) && pmem_resp;

  sat_counter #(.CNT_W(CNT_W)) wbCounter (
    .clk   (clk),
    .reset (reset),
    .inc   (wbDone),
    .count (wb_count)
  );

  sat_counter #(.CNT_W(CNT_W)) fillCounter (
    .clk   (clk),
    .reset (reset),
    .inc   (fillDone),
    .count (fill_count)
  );

endmodule

// File: tb/tb_cache_line_mover.sv
// tb_cache_line_mover
//   Directed bench for cache_line_mover. A table of miss scenarios is played
//   through a cycle-accurate pmem responder; a second instance with 2-bit
//   counters shares the stimulus to exercise counter saturation.
module tb_cache_line_mover;

  logic         clk;
  logic         reset;
  logic         req;
  logic [8:0]   req_tag;
  logic [2:0]   req_index;
  logic         victim_valid;
  logic         victim_dirty;
  logic [8:0]   victim_tag;
  logic [127:0] victim_data;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;

  logic [2:0]   set_index;
  logic         set_load;
  logic         set_write_type;
  logic [8:0]   set_in_tag;
  logic [127:0] set_in_data;
  logic [15:0]  pmem_address;
  logic         pmem_read;
  logic         pmem_write;
  logic [127:0] pmem_wdata;
  logic         busy;
  logic         done;
  logic [15:0]  wb_count;
  logic [15:0]  fill_count;

  logic [2:0]   set_index2;
  logic         set_load2;
  logic         set_write_type2;
  logic [8:0]   set_in_tag2;
  logic [127:0] set_in_data2;
  logic [15:0]  pmem_address2;
  logic         pmem_read2;
  logic         pmem_write2;
  logic [127:0] pmem_wdata2;
  logic         busy2;
  logic         done2;
  logic [1:0]   wb_count2;
  logic [1:0]   fill_count2;

  int checks   = 0;
  int failures = 0;
  int expWb    = 0;
  int expFill  = 0;

  cache_line_mover dut (
    .clk(clk), .reset(reset), .req(req), .req_tag(req_tag), .req_index(req_index),
    .victim_valid(victim_valid), .victim_dirty(victim_dirty),
    .victim_tag(victim_tag), .victim_data(victim_data),
    .set_index(set_index), .set_load(set_load), .set_write_type(set_write_type),
    .set_in_tag(set_in_tag), .set_in_data(set_in_data),
    .pmem_address(pmem_address), .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
    .busy(busy), .done(done), .wb_count(wb_count), .fill_count(fill_count)
  );

  cache_line_mover #(.CNT_W(2)) dutSmall (
    .clk(clk), .reset(reset), .req(req), .req_tag(req_tag), .req_index(req_index),
    .victim_valid(victim_valid), .victim_dirty(victim_dirty),
    .victim_tag(victim_tag), .victim_data(victim_data),
    .set_index(set_index2), .set_load(set_load2), .set_write_type(set_write_type2),
    .set_in_tag(set_in_tag2), .set_in_data(set_in_data2),
    .pmem_address(pmem_address2), .pmem_read(pmem_read2), .pmem_write(pmem_write2),
    .pmem_wdata(pmem_wdata2), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
    .busy(busy2), .done(done2), .wb_count(wb_count2), .fill_count(fill_count2)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic         vValid;
    logic         vDirty;
    logic [8:0]   vTag;
    logic [127:0] vData;
    logic [8:0]   rTag;
    logic [2:0]   rIndex;
    int           lw;
    int           lr;
    logic [127:0] rData;
    logic         expWbSeen;
    logic [15:0]  expWbAddr;
    logic [15:0]  expRdAddr;
  } missVec_t;

  missVec_t vecs[5];

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string name, input logic [127:0] act,
                             input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Counter expectations for both instances; the small one pins at 3.
  task automatic checkCounters(input string tagName);
    checkOutput({tagName, "_wbCount"}, 128'(wb_count), 128'(expWb));
    checkOutput({tagName, "_fillCount"}, 128'(fill_count), 128'(expFill));
    checkOutput({tagName, "_wbCountSat"}, 128'(wb_count2), 128'((expWb > 3) ? 3 : expWb));
    checkOutput({tagName, "_fillCountSat"}, 128'(fill_count2), 128'((expFill > 3) ? 3 : expFill));
  endtask

  // Idle-state outputs: strobes low, buses zero.
  task automatic checkIdle(input string tagName);
    checkOutput({tagName, "_busy"}, 128'(busy), 128'(0));
    checkOutput({tagName, "_done"}, 128'(done), 128'(0));
    checkOutput({tagName, "_pmemRead"}, 128'(pmem_read), 128'(0));
    checkOutput({tagName, "_pmemWrite"}, 128'(pmem_write), 128'(0));
    checkOutput({tagName, "_setLoad"}, 128'(set_load), 128'(0));
    checkOutput({tagName, "_pmemAddress"}, 128'(pmem_address), 128'(0));
  endtask

  // Run one miss from the accepting edge to the end of DONE, acting as the
  // controller and as pmem. Inputs the DUT should have latched are scrambled
  // after acceptance; pmem_rdata carries junk except in the resp cycle.
  task automatic applyStimulus(input missVec_t v, input string tagName);
    int  cyc;
    int  wbCycles;
    int  rdCycles;
    int  loads;
    int  expDone;
    bit  doneSeen;
    bit  wbSeen;
    bit  rdSeen;
    bit  orderBad;
    cyc = 0; wbCycles = 0; rdCycles = 0; loads = 0;
    doneSeen = 0; wbSeen = 0; rdSeen = 0; orderBad = 0;
    expDone = (v.expWbSeen ? v.lw : 0) + v.lr + 2;

    req_tag      = v.rTag;
    req_index    = v.rIndex;
    victim_valid = v.vValid;
    victim_dirty = v.vDirty;
    victim_tag   = v.vTag;
    victim_data  = v.vData;
    pmem_resp    = 1'b0;
    pmem_rdata   = ~v.rData;
    req          = 1'b1;
    #1;
    checkOutput({tagName, "_idleSetIndex"}, 128'(set_index), 128'(v.rIndex));
    @(posedge clk); #1;
    victim_valid = ~v.vValid;
    victim_dirty = ~v.vDirty;
    victim_tag   = ~v.vTag;
    victim_data  = ~v.vData;
    req_tag      = ~v.rTag;
    req_index    = ~v.rIndex;
    cyc = 1;

    while (!doneSeen && cyc <= 40) begin
      pmem_resp  = 1'b0;
      pmem_rdata = ~v.rData;
      if (!busy || (set_index !== v.rIndex) || (pmem_read && pmem_write)) begin
        checkOutput({tagName, "_busyIndexExcl"}, {busy, set_index, pmem_read & pmem_write},
                    {1'b1, v.rIndex, 1'b0});
      end
      if (pmem_write) begin
        if (!wbSeen) begin
          checkOutput({tagName, "_wbAddr"}, 128'(pmem_address), 128'(v.expWbAddr));
          checkOutput({tagName, "_wbData"}, pmem_wdata, v.vData);
        end
        if (rdSeen) orderBad = 1;
        wbSeen = 1;
        wbCycles++;
        if (wbCycles == v.lw) pmem_resp = 1'b1;
      end
      if (pmem_read) begin
        if (!rdSeen) checkOutput({tagName, "_rdAddr"}, 128'(pmem_address), 128'(v.expRdAddr));
        rdSeen = 1;
        rdCycles++;
        if (rdCycles == v.lr) begin
          pmem_resp  = 1'b1;
          pmem_rdata = v.rData;
        end
      end
      if (set_load) begin
        loads++;
        checkOutput({tagName, "_loadTag"}, 128'(set_in_tag), 128'(v.rTag));
        checkOutput({tagName, "_loadData"}, set_in_data, v.rData);
        checkOutput({tagName, "_writeType"}, 128'(set_write_type), 128'(0));
        pmem_resp = 1'b1;
      end
      if (done) begin
        doneSeen = 1;
        checkOutput({tagName, "_doneCycle"}, 128'(cyc), 128'(expDone));
        pmem_resp = 1'b1;
        req       = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end

    pmem_resp = 1'b0;
    if (!doneSeen) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s_timeout: got no done expected done by cycle %0d", tagName, expDone);
      req = 1'b0;
    end
    checkOutput({tagName, "_wbSeen"}, 128'(wbSeen), 128'(v.expWbSeen));
    checkOutput({tagName, "_wbCycles"}, 128'(wbCycles), 128'(v.expWbSeen ? v.lw : 0));
    checkOutput({tagName, "_rdCycles"}, 128'(rdCycles), 128'(v.lr));
    checkOutput({tagName, "_loadCount"}, 128'(loads), 128'(1));
    checkOutput({tagName, "_wbBeforeRead"}, 128'(orderBad), 128'(0));
    checkIdle({tagName, "_after"});
    if (v.expWbSeen) expWb++;
    expFill++;
    checkCounters(tagName);
  endtask

  initial begin
    // Hand-computed addresses: {tag, index, 4'b0}.
    vecs[0] = '{1'b1, 1'b0, 9'h005, {4{32'h0BAD_F00D}}, 9'h1A3, 3'd2, 0, 3,
                {4{32'hDEAD_BEEF}}, 1'b0, 16'h0000, 16'hD1A0};
    vecs[1] = '{1'b1, 1'b1, 9'h0F0, {4{32'h1111_1111}}, 9'h001, 3'd7, 2, 2,
                {4{32'h2222_3333}}, 1'b1, 16'h7870, 16'h00F0};
    vecs[2] = '{1'b0, 1'b1, 9'h1FF, {4{32'h4444_5555}}, 9'h0AA, 3'd5, 0, 1,
                {4{32'h6666_7777}}, 1'b0, 16'h0000, 16'h5550};
    vecs[3] = '{1'b1, 1'b1, 9'h100, {4{32'h8888_9999}}, 9'h002, 3'd0, 1, 1,
                {4{32'hAAAA_BBBB}}, 1'b1, 16'h8000, 16'h0100};
    vecs[4] = '{1'b0, 1'b0, 9'h000, {4{32'hCCCC_DDDD}}, 9'h1FF, 3'd3, 0, 2,
                {4{32'hEEEE_FFFF}}, 1'b0, 16'h0000, 16'hFFB0};

    reset        = 1'b1;
    req          = 1'b0;
    req_tag      = '0;
    req_index    = '0;
    victim_valid = 1'b0;
    victim_dirty = 1'b0;
    victim_tag   = '0;
    victim_data  = '0;
    pmem_rdata   = '0;
    pmem_resp    = 1'b0;
    #2;
    checkIdle("reset");
    checkOutput("reset_wdata", pmem_wdata, 128'(0));
    checkOutput("reset_setInTag", 128'(set_in_tag), 128'(0));
    checkOutput("reset_setInData", set_in_data, 128'(0));
    checkCounters("reset");
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 5; i++) begin
      applyStimulus(vecs[i], $sformatf("vec%0d", i));
      // A stray pmem_resp while idle must be ignored.
      pmem_resp = 1'b1;
      @(posedge clk); #1;
      pmem_resp = 1'b0;
      checkIdle($sformatf("idleResp%0d", i));
      checkCounters($sformatf("idleResp%0d", i));
    end

    // Reset in the middle of FILL aborts without waiting for a clock edge.
    req_tag      = vecs[0].rTag;
    req_index    = vecs[0].rIndex;
    victim_valid = 1'b1;
    victim_dirty = 1'b0;
    victim_tag   = vecs[0].vTag;
    victim_data  = vecs[0].vData;
    req          = 1'b1;
    @(posedge clk); #1;
    checkOutput("abort_inFill", 128'(pmem_read), 128'(1));
    @(posedge clk); #1;
    #2;
    reset = 1'b1;
    #1;
    req = 1'b0;
    checkIdle("abort");
    expWb   = 0;
    expFill = 0;
    checkCounters("abort");
    @(posedge clk); #1;
    checkOutput("abort_noLoad", 128'(set_load), 128'(0));
    reset = 1'b0;
    @(posedge clk); #1;
    applyStimulus(vecs[0], "afterAbort");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
